barrel_rotator_pipe: RTL and testbench

- Parametrised, pipelined successor to the 8-bit combinational left/right rotator.
- Rotates or shifts a WIDTH-bit word left or right by a runtime amount. Modes: rotate, logical shift, and optional arithmetic shift.
- One log2 stage per pipeline register, with valid/ready handshake on both sides.
- Sits between a producer (switch/UART capture) and a consumer (display/LED driver) on the board's single clock domain.

---
 rtl/barrel_rotator_pipe_pkg.sv | 43 ++++
 rtl/barrel_rotator_pipe_if.sv | 39 +++
 rtl/barrel_rotator_pipe_stage.sv | 89 ++++++++
 rtl/barrel_rotator_pipe.sv | 73 +++++++
 tb/tb_barrel_rotator_pipe.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/barrel_rotator_pipe_pkg.sv
// -----------------------------------------------------------------------------
// barrel_pkg: shared constants and helpers for the pipelined barrel rotator.
//
// Contents:
//   MODE_ROT/MODE_LSH/MODE_ASH/MODE_RSV  external 2-bit mode encodings
//   DIR_LEFT/DIR_RIGHT                   direction encodings
//   mode_t                               internal (carried) mode type
//   decode_mode()                        external mode -> internal mode
//
// Build option: BARREL_ARITH_EN
//   defined   : mode_t is 2 bits, arithmetic right shift is supported.
//   undefined : mode_t is a single "shift (1) vs rotate (0)" bit and
//               MODE_ASH decodes as a logical shift.
// -----------------------------------------------------------------------------
package barrel_pkg;

   localparam logic [1:0] MODE_ROT = 2'b00;
   localparam logic [1:0] MODE_LSH = 2'b01;
   localparam logic [1:0] MODE_ASH = 2'b10;
   localparam logic [1:0] MODE_RSV = 2'b11;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

`ifdef BARREL_ARITH_EN
   localparam int MODE_W = 2;
`else
   localparam int MODE_W = 1;
`endif

   typedef logic [MODE_W-1:0] mode_t;

   // Reserved mode is folded into rotate once at the pipeline entry so the
   // stages only ever see the codes they implement.
   function automatic mode_t decode_mode(input logic [1:0] mode);
`ifdef BARREL_ARITH_EN
      return (mode == MODE_RSV) ? MODE_ROT : mode;
`else
      return mode_t'((mode == MODE_LSH) || (mode == MODE_ASH));
`endif
   endfunction

endpackage

// File: rtl/barrel_rotator_pipe_if.sv
// -----------------------------------------------------------------------------
// barrel_rotator_pipe_if: request/result handshake bundle of the rotator.
//
// Signals:
//   in_valid/in_ready    request handshake (producer -> rotator)
//   in_data/in_amt       operand and shift amount (0..WIDTH-1)
//   in_dir               1 = right, 0 = left
//   in_mode              00 rotate, 01 logical, 10 arithmetic, 11 rotate
//   out_valid/out_ready  result handshake (rotator -> consumer)
//   out_data             result word
//
// Modports: master = producer/consumer side, slave = rotator side.
// -----------------------------------------------------------------------------
interface barrel_rotator_pipe_if #(
   parameter int WIDTH = 8
);
   localparam int LOG2W = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [LOG2W-1:0] in_amt;
   logic             in_dir;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, in_amt, in_dir, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_dir, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/barrel_rotator_pipe_stage.sv
// -----------------------------------------------------------------------------
// barrel_stage: one log2 step of the barrel rotator plus its pipeline register.
//
// Shifts the incoming word by STEP positions when amount bit log2(STEP) is set,
// otherwise passes it through, then registers data/amt/dir/mode/valid.
// Registers load only when en (pipeline advance) is high.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset (clears all)
//   en                    pipeline advance
//   vld_in .. mode_in     previous stage (or request) fields
//   vld_p .. mode_p       registered fields of this stage
//
// Build option: BARREL_ARITH_EN enables the sign-replicating right shift.
// -----------------------------------------------------------------------------
module barrel_stage
   import barrel_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             vld_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AMT_W-1:0] amt_in,
   input  logic             dir_in,
   input  mode_t            mode_in,
   output logic             vld_p,
   output logic [WIDTH-1:0] data_p,
   output logic [AMT_W-1:0] amt_p,
   output logic             dir_p,
   output mode_t            mode_p
);

   localparam int BIT = $clog2(STEP);

   logic [WIDTH-1:0] shifted;

   function automatic logic [WIDTH-1:0] step_shift(input logic [WIDTH-1:0] d,
                                                   input logic dir,
                                                   input mode_t mode);
      logic            rot;
      logic [STEP-1:0] fill_l;
      logic [STEP-1:0] fill_r;
`ifdef BARREL_ARITH_EN
      logic signed [WIDTH-1:0] sd;
      rot = (mode == MODE_ROT);
`else
      rot = !mode[0];
`endif
      // Rotate refills from the opposite end; shifts refill with zeros.
      fill_l = rot ? d[WIDTH-1 -: STEP] : '0;
      fill_r = rot ? d[STEP-1:0] : '0;
      if (dir == DIR_LEFT) begin
         return {d[WIDTH-STEP-1:0], fill_l};
      end
`ifdef BARREL_ARITH_EN
      // MSB never changes in an arithmetic right step, so replicating the
      // current MSB at every stage equals replicating the original sign.
      if (mode == MODE_ASH) begin
         sd = d;
         return sd >>> STEP;
      end
`endif
      return {fill_r, d[WIDTH-1:STEP]};
   endfunction

   assign shifted = amt_in[BIT] ? step_shift(data_in, dir_in, mode_in) : data_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p  <= 1'b0;
         data_p <= '0;
         amt_p  <= '0;
         dir_p  <= 1'b0;
         mode_p <= '0;
      end else if (en) begin
         vld_p  <= vld_in;
         data_p <= shifted;
         amt_p  <= amt_in;
         dir_p  <= dir_in;
         mode_p <= mode_in;
      end
   end

endmodule

// File: rtl/barrel_rotator_pipe.sv
// -----------------------------------------------------------------------------
// barrel_rotator_pipe: pipelined WIDTH-bit rotate / logical / arithmetic shifter.
//
// LOG2W register stages; stage k shifts by 2^k. Latency LOG2W edges, one
// request per cycle. The whole pipeline advances together when the output
// register is empty or being drained (in_ready = advance, combinational from
// out_ready). A stall freezes every stage, bubbles included.
//
// Ports:
//   clk    system clock (rising edge)
//   reset  synchronous active-high reset, flushes all in-flight requests
//   bus    barrel_rotator_pipe_if.slave (in_* request, out_* result)
//
// Build option: BARREL_ARITH_EN (mode 10 = arithmetic shift; otherwise logical).
// -----------------------------------------------------------------------------
module barrel_rotator_pipe
   import barrel_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   barrel_rotator_pipe_if.slave  bus
);

   localparam int LOG2W = $clog2(WIDTH);

   logic                        advance;
   logic [LOG2W:0]              vld_c;
   logic [LOG2W:0][WIDTH-1:0]   data_c;
   logic [LOG2W:0][LOG2W-1:0]   amt_c;
   logic [LOG2W:0]              dir_c;
   mode_t [LOG2W:0]             mode_c;
   logic                        unused_tail;

   assign advance   = !vld_c[LOG2W] || bus.out_ready;
   assign bus.in_ready  = advance;
   assign bus.out_valid = vld_c[LOG2W];
   assign bus.out_data  = data_c[LOG2W];

   // Entry point: an idle input simply loads a bubble into stage 0.
   assign vld_c[0]  = bus.in_valid;
   assign data_c[0] = bus.in_data;
   assign amt_c[0]  = bus.in_amt;
   assign dir_c[0]  = bus.in_dir;
   assign mode_c[0] = decode_mode(bus.in_mode);

   for (genvar k = 0; k < LOG2W; k++) begin : g_stage
      barrel_stage #(
         .WIDTH (WIDTH),
         .STEP  (1 << k),
         .AMT_W (LOG2W)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .en      (advance),
         .vld_in  (vld_c[k]),
         .data_in (data_c[k]),
         .amt_in  (amt_c[k]),
         .dir_in  (dir_c[k]),
         .mode_in (mode_c[k]),
         .vld_p   (vld_c[k+1]),
         .data_p  (data_c[k+1]),
         .amt_p   (amt_c[k+1]),
         .dir_p   (dir_c[k+1]),
         .mode_p  (mode_c[k+1])
      );
   end

   // Control fields of the last stage have no consumer.
   assign unused_tail = ^{amt_c[LOG2W], dir_c[LOG2W], mode_c[LOG2W]};

endmodule

// File: tb/tb_barrel_rotator_pipe.sv
// -----------------------------------------------------------------------------
// tb_barrel_rotator_pipe: self-checking bench for barrel_rotator_pipe (WIDTH=8).
// Directed vector table, backpressure and mid-flight reset sequences, an
// exhaustive rotate/logical sweep and a randomized phase, all scored against
// an arithmetic reference model through an in-order scoreboard.
// -----------------------------------------------------------------------------
module tb_barrel_rotator_pipe;

   localparam int W  = 8;
   localparam int LW = $clog2(W);

`ifdef BARREL_ARITH_EN
   localparam logic [7:0] ASH_EXP = 8'hE4;
`else
   localparam logic [7:0] ASH_EXP = 8'h24;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   barrel_rotator_pipe_if #(.WIDTH(W)) bus ();

   barrel_rotator_pipe #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [7:0] data;
      logic [2:0] amt;
      logic       dir;
      logic [1:0] mode;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      logic [7:0] exp;
      int         acc;
   } pend_t;

   vec_t  tbl [12];
   pend_t pend [$];
   pend_t mp;
   int    checks = 0;
   int    errors = 0;
   int    n_out  = 0;
   bit    check_lat = 1'b0;

   // Reference: whole-word shifts on a wide integer, then truncate.
   function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input int a,
                                              input logic dir, input logic [1:0] mode);
      longint unsigned v, r, mask;
      bit rot, ash;
      v    = 64'(d);
      mask = (64'd1 << W) - 1;
      rot  = (mode == 2'b00) || (mode == 2'b11);
`ifdef BARREL_ARITH_EN
      ash  = (mode == 2'b10);
`else
      ash  = 1'b0;
`endif
      if (rot)
         r = dir ? ((v >> a) | (v << (W - a))) : ((v << a) | (v >> (W - a)));
      else if (!dir)
         r = v << a;
      else begin
         r = v >> a;
         if (ash && d[W-1]) r = r | (mask & ~(mask >> a));
      end
      return r[W-1:0];
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_idle();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_amt   = '0;
      bus.in_dir   = 1'b0;
      bus.in_mode  = 2'b00;
   endtask

   initial begin
      bit           found;
      int           k, sent, nstall, base;
      logic [7:0]   got [$];
      int           got_t [$];

      tbl[0]  = '{8'h81, 3'd1, 1'b1, 2'b00, 8'hC0};
      tbl[1]  = '{8'hA5, 3'd3, 1'b0, 2'b00, 8'h2D};
      tbl[2]  = '{8'hF0, 3'd4, 1'b1, 2'b01, 8'h0F};
      tbl[3]  = '{8'h81, 3'd7, 1'b0, 2'b01, 8'h80};
      tbl[4]  = '{8'h5A, 3'd0, 1'b0, 2'b00, 8'h5A};
      tbl[5]  = '{8'h5A, 3'd0, 1'b1, 2'b01, 8'h5A};
      tbl[6]  = '{8'h5A, 3'd0, 1'b1, 2'b10, 8'h5A};
      tbl[7]  = '{8'h5A, 3'd0, 1'b0, 2'b11, 8'h5A};
      tbl[8]  = '{8'h90, 3'd2, 1'b1, 2'b10, ASH_EXP};
      tbl[9]  = '{8'h90, 3'd1, 1'b0, 2'b10, 8'h20};
      tbl[10] = '{8'h81, 3'd1, 1'b1, 2'b11, 8'hC0};
      tbl[11] = '{8'h01, 3'd7, 1'b1, 2'b00, 8'h02};

      reset = 1'b1;
      drive_idle();
      bus.out_ready = 1'b1;

      // Scoreboard: every input transfer is modelled, every output popped.
      fork
         forever begin
            @(negedge clk);
            if (reset) begin
               pend.delete();
            end else begin
               if (bus.out_valid && bus.out_ready) begin
                  n_out++;
                  if (pend.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL sb_unexpected: got %0h expected no output (cycle %0d)",
                              bus.out_data, cyc);
                  end else begin
                     mp = pend.pop_front();
                     chk("sb_data", int'(bus.out_data), int'(mp.exp));
                     if (check_lat) chk("sb_latency", cyc - mp.acc, LW);
                  end
               end
               if (bus.in_valid && bus.in_ready) begin
                  mp.exp = ref_model(bus.in_data, int'(bus.in_amt), bus.in_dir, bus.in_mode);
                  mp.acc = cyc;
                  pend.push_back(mp);
               end
            end
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", int'(bus.in_ready), 1);

      // Directed vectors, one at a time
      check_lat = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b1;
         bus.in_data  = tbl[i].data;
         bus.in_amt   = tbl[i].amt;
         bus.in_dir   = tbl[i].dir;
         bus.in_mode  = tbl[i].mode;
         @(posedge clk); #1;
         drive_idle();
         found = 1'b0;
         k = 0;
         while (!found && k < 8) begin
            @(negedge clk);
            k++;
            if (bus.out_valid) found = 1'b1;
         end
         if (!found) begin
            checks++;
            errors++;
            $display("FAIL tbl_timeout[%0d]: got no out_valid expected %0h", i, tbl[i].exp);
         end else begin
            chk($sformatf("tbl_data[%0d]", i), int'(bus.out_data), int'(tbl[i].exp));
            @(negedge clk);
            chk($sformatf("tbl_pulse[%0d]", i), int'(bus.out_valid), 0);
         end
      end

      // Backpressure: six rotate-left-by-1 requests, consumer stalls 5 cycles
      check_lat = 1'b0;
      sent = 0;
      nstall = 0;
      for (int t = 0; t < 24; t++) begin
         @(posedge clk); #1;
         bus.out_ready = !(t >= 3 && t < 8);
         bus.in_valid  = (sent < 6);
         bus.in_data   = 8'(sent + 1);
         bus.in_amt    = 3'd1;
         bus.in_dir    = 1'b0;
         bus.in_mode   = 2'b00;
         @(negedge clk);
         if (bus.out_valid && !bus.out_ready) begin
            nstall++;
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_hold", int'(bus.out_data), 8'h02);
         end
         if (bus.out_valid && bus.out_ready) begin
            got.push_back(bus.out_data);
            got_t.push_back(t);
         end
         if (bus.in_valid && bus.in_ready) sent++;
      end
      @(posedge clk); #1;
      drive_idle();
      bus.out_ready = 1'b1;
      chk("bp_stall_cycles", nstall, 5);
      chk("bp_count", got.size(), 6);
      for (int i = 0; i < got.size(); i++) begin
         chk($sformatf("bp_order[%0d]", i), int'(got[i]), (i + 1) * 2);
         if (i > 0) chk($sformatf("bp_gap[%0d]", i), got_t[i] - got_t[i-1], 1);
      end

      // Mid-flight reset: three requests accepted, then reset, none emerge
      repeat (4) @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      for (int t = 0; t < 3; t++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(8'h30 + t);
         bus.in_amt   = 3'(t + 1);
         bus.in_dir   = 1'b1;
         bus.in_mode  = 2'b00;
         @(negedge clk);
         chk("mr_accept", int'(bus.in_ready), 1);
         @(posedge clk); #1;
      end
      drive_idle();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mr_out_valid", int'(bus.out_valid), 0);
      chk("mr_out_data", int'(bus.out_data), 0);
      chk("mr_in_ready", int'(bus.in_ready), 1);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         chk("mr_no_ghost", int'(bus.out_valid), 0);
      end

      // Exhaustive sweep of rotate and logical modes, back to back
      check_lat = 1'b1;
      base = n_out;
      for (int m = 0; m < 2; m++)
         for (int d = 0; d < 2; d++)
            for (int a = 0; a < 8; a++)
               for (int v = 0; v < 256; v++) begin
                  @(posedge clk); #1;
                  bus.in_valid = 1'b1;
                  bus.in_data  = 8'(v);
                  bus.in_amt   = 3'(a);
                  bus.in_dir   = d[0];
                  bus.in_mode  = 2'(m);
               end
      @(posedge clk); #1;
      drive_idle();
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("sweep_count", n_out - base, 8192);

      // Randomized traffic with random consumer stalls, all modes
      check_lat = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         @(posedge clk); #1;
         bus.in_valid  = ($urandom_range(3) != 0);
         bus.in_data   = 8'($urandom);
         bus.in_amt    = 3'($urandom);
         bus.in_dir    = 1'($urandom);
         bus.in_mode   = 2'($urandom);
         bus.out_ready = ($urandom_range(2) != 0);
      end
      @(posedge clk); #1;
      drive_idle();
      bus.out_ready = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("drain_empty", pend.size(), 0);
      chk("drain_out_valid", int'(bus.out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
